alu_control_seq: RTL

ALU_CONTROL_SEQ -- requirements
Module: alu_control_seq

---
 rtl/alu_control_seq.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/alu_control_seq.sv
// ALU control decoder with a multi-cycle mult/div sequencer. Optional divide support: ALU_CONTROL_SEQ_DIV_EN.
// Latency: 1 cycle for single-cycle ops; mult/div runs XLEN step cycles plus one DONE cycle.
// Backpressure: busy stalls upstream and valid_in is ignored while busy; DONE accepts a new op with no bubble.
module alu_control_seq #(
    parameter int OPW  = 5,
    parameter int XLEN = 32
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           valid_in,
    input  logic [5:0]     funct,
    input  logic [1:0]     alu_op,
    output logic [OPW-1:0] op_code,
    output logic           op_valid,
    output logic           busy,
    output logic           seq_start,
    output logic           seq_step,
    output logic           hilo_we,
    output logic           illegal
);

    localparam int            CW       = (XLEN > 1) ? $clog2(XLEN) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MUL_RUN = 2'd1,
`ifdef ALU_CONTROL_SEQ_DIV_EN
        DONE    = 2'd2,
        DIV_RUN = 2'd3
`else
        DONE    = 2'd2
`endif
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [OPW-1:0]  code_nxt;
    logic            vld_nxt;
    logic            ill_nxt;

    logic [3:0]      dec_code;
    logic            dec_mul;
    logic            dec_ill;
`ifdef ALU_CONTROL_SEQ_DIV_EN
    logic            dec_div;
`endif

    always_comb begin
        dec_code = 4'd0;
        dec_mul  = 1'b0;
        dec_ill  = 1'b0;
`ifdef ALU_CONTROL_SEQ_DIV_EN
        dec_div  = 1'b0;
`endif
        case (alu_op)
            2'b00: dec_code = 4'd2;
            2'b01: dec_code = 4'd6;
            2'b10: begin
                case (funct)
                    6'b100000: dec_code = 4'd2;
                    6'b100010: dec_code = 4'd6;
                    6'b100100: dec_code = 4'd0;
                    6'b100101: dec_code = 4'd1;
                    6'b101010: dec_code = 4'd7;
                    6'b001000: dec_code = 4'd3;
                    6'b000000: dec_code = 4'd4;
                    6'b000010: dec_code = 4'd5;
                    6'b011000: begin
                        dec_code = 4'd8;
                        dec_mul  = 1'b1;
                    end
`ifdef ALU_CONTROL_SEQ_DIV_EN
                    6'b011010: begin
                        dec_code = 4'd9;
                        dec_div  = 1'b1;
                    end
`endif
                    6'b010000: dec_code = 4'd10;
                    6'b010010: dec_code = 4'd11;
                    default:   dec_ill  = 1'b1;
                endcase
            end
            default: dec_ill = 1'b1;
        endcase
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        code_nxt  = op_code;
        vld_nxt   = 1'b0;
        ill_nxt   = 1'b0;
        case (state)
            IDLE, DONE: begin
                state_nxt = IDLE;
                if (valid_in) begin
                    if (dec_mul) begin
                        state_nxt = MUL_RUN;
                        cnt_nxt   = '0;
                    end
`ifdef ALU_CONTROL_SEQ_DIV_EN
                    else if (dec_div) begin
                        state_nxt = DIV_RUN;
                        cnt_nxt   = '0;
                    end
`endif
                    else begin
                        code_nxt = dec_ill ? '1 : OPW'(dec_code);
                        vld_nxt  = 1'b1;
                        ill_nxt  = dec_ill;
                    end
                end
            end
            MUL_RUN: begin
                // Clear rather than increment on the last step so the counter never wraps.
                if (cnt == CNT_LAST) begin
                    state_nxt = DONE;
                    cnt_nxt   = '0;
                    code_nxt  = OPW'(4'd8);
                    vld_nxt   = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
`ifdef ALU_CONTROL_SEQ_DIV_EN
            DIV_RUN: begin
                if (cnt == CNT_LAST) begin
                    state_nxt = DONE;
                    cnt_nxt   = '0;
                    code_nxt  = OPW'(4'd9);
                    vld_nxt   = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
`endif
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            op_code  <= '0;
            op_valid <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            op_code  <= code_nxt;
            op_valid <= vld_nxt;
            illegal  <= ill_nxt;
        end
    end

`ifdef ALU_CONTROL_SEQ_DIV_EN
    assign busy = (state == MUL_RUN) || (state == DIV_RUN);
`else
    assign busy = (state == MUL_RUN);
`endif
    assign seq_step  = busy;
    assign seq_start = busy && (cnt == '0);
    assign hilo_we   = (state == DONE);

endmodule
